// File: rtl/imm_pkg.sv
// Immediate-format constants, field positions and the pure encode/range helpers.
// Shared with the immediate extender so both sides agree on immsrc coding.
// Combinational only; no latency or backpressure.
package imm_pkg;

  localparam logic [1:0] IMMSRC_I    = 2'b00;
  localparam logic [1:0] IMMSRC_S    = 2'b01;
  localparam logic [1:0] IMMSRC_B    = 2'b10;
  localparam logic [1:0] IMMSRC_RSVD = 2'b11;

  localparam int I_HI    = 31;
  localparam int I_LO    = 20;
  localparam int S_HI_HI = 31;
  localparam int S_HI_LO = 25;
  localparam int S_LO_HI = 11;
  localparam int S_LO_LO = 7;
  localparam int B_B12   = 31;
  localparam int B_B11   = 7;
  localparam int B_HI_HI = 30;
  localparam int B_HI_LO = 25;
  localparam int B_LO_HI = 11;
  localparam int B_LO_LO = 8;

  // Out-of-range immediates are silently truncated here; flagging is the caller's job.
  function automatic logic [31:0] imm_encode(input logic [31:0] instr,
                                             input logic [1:0]  immsrc,
                                             input logic [31:0] imm);
    logic [31:0] r;
    r = instr;
    case (immsrc)
      IMMSRC_I: r[I_HI:I_LO] = imm[11:0];
      IMMSRC_S: begin
        r[S_HI_HI:S_HI_LO] = imm[11:5];
        r[S_LO_HI:S_LO_LO] = imm[4:0];
      end
      IMMSRC_B: begin
        r[B_B12]           = imm[12];
        r[B_B11]           = imm[11];
        r[B_HI_HI:B_HI_LO] = imm[10:5];
        r[B_LO_HI:B_LO_LO] = imm[4:1];
      end
      default: r = instr;
    endcase
    return r;
  endfunction

  function automatic logic imm_in_range(input logic [1:0]  immsrc,
                                        input logic [31:0] imm);
    logic ok;
    case (immsrc)
      IMMSRC_I, IMMSRC_S: ok = (&imm[31:11]) | ~(|imm[31:11]);
      IMMSRC_B:           ok = ((&imm[31:12]) | ~(|imm[31:12])) & ~imm[0];
      default:            ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/imm_encoder_if.sv
// Valid/ready bus into and out of the immediate encoder.
// No logic; slave modport is the encoder side.
// Backpressure carried by in_ready/out_ready.
interface imm_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_immsrc;
  logic [31:0] in_imm;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;

  modport master (
    output in_valid, in_immsrc, in_imm, in_instr, out_ready,
    input  in_ready, out_valid, out_instr, out_err
  );

  modport slave (
    input  in_valid, in_immsrc, in_imm, in_instr, out_ready,
    output in_ready, out_valid, out_instr, out_err
  );
endinterface

// File: rtl/imm_enc_skid.sv
// Two-entry valid/ready buffer: output register plus one skid slot.
// Latency 1 cycle; full throughput when downstream is ready.
// in_rdy is the registered "skid empty" flag, so upstream never sees a combinational path.
module imm_enc_skid #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_vld,
  output logic         in_rdy,
  input  logic [W-1:0] in_dat,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic [W-1:0] out_dat
);

  logic         skid_vld;
  logic [W-1:0] skid_dat;

  assign in_rdy = ~skid_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld  <= 1'b0;
      out_dat  <= '0;
      skid_vld <= 1'b0;
      skid_dat <= '0;
    end else if (!out_vld || out_rdy) begin
      // Output slot frees up: the older skid word always goes first.
      if (skid_vld) begin
        out_vld  <= 1'b1;
        out_dat  <= skid_dat;
        skid_vld <= 1'b0;
      end else begin
        out_vld <= in_vld;
        if (in_vld) out_dat <= in_dat;
      end
    end else if (in_vld && !skid_vld) begin
      skid_vld <= 1'b1;
      skid_dat <= in_dat;
    end
  end

endmodule

// File: rtl/imm_encoder.sv
// Inserts a signed immediate into I/S/B fields; IMMENC_RANGE_CHECK_EN builds out_err/err_count.
// Latency 1 cycle (encode in front of a registered skid buffer), one word per cycle.
// Holds up to 2 words under out_ready=0, then drops in_ready.
module imm_encoder
  import imm_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  imm_encoder_if.slave     bus,
  output logic [CNT_W-1:0] enc_count,
  output logic [CNT_W-1:0] err_count
);

  logic [31:0] enc_instr;
  logic        enc_err;
  logic        in_rdy;
  logic        out_vld;
  logic [32:0] out_dat;
  logic        out_fire;

  always_comb begin
    enc_instr = imm_encode(bus.in_instr, bus.in_immsrc, bus.in_imm);
`ifdef IMMENC_RANGE_CHECK_EN
    enc_err = ~imm_in_range(bus.in_immsrc, bus.in_imm);
`else
    enc_err = 1'b0;
`endif
  end

  imm_enc_skid #(.W(33)) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_vld  (bus.in_valid),
    .in_rdy  (in_rdy),
    .in_dat  ({enc_err, enc_instr}),
    .out_vld (out_vld),
    .out_rdy (bus.out_ready),
    .out_dat (out_dat)
  );

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = out_vld;
  assign bus.out_instr = out_dat[31:0];
  assign bus.out_err   = out_dat[32];
  assign out_fire      = out_vld & bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enc_count <= '0;
    end else if (out_fire && !(&enc_count)) begin
      enc_count <= enc_count + 1'b1;
    end
  end

`ifdef IMMENC_RANGE_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (out_fire && out_dat[32] && !(&err_count)) begin
      err_count <= err_count + 1'b1;
    end
  end
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_imm_encoder.sv
// Randomized bench for imm_encoder against an arithmetic reference (extender decode + signed range).
// Narrow counters so saturation is reached within the run.
module tb_imm_encoder;
  import imm_pkg::*;

  localparam int CW   = 4;
  localparam int CMAX = 15;
`ifdef IMMENC_RANGE_CHECK_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [CW-1:0] enc_count;
  logic [CW-1:0] err_count;

  imm_encoder_if bus ();

  imm_encoder #(.CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .enc_count (enc_count),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] tmpl;
    logic [1:0]  src;
    logic [31:0] imm;
  } word_t;

  word_t       sb[$];
  int          errors = 0;
  int          checks = 0;
  int          m_enc = 0;
  int          m_err = 0;
  int          n_out = 0;
  bit          last_acc = 1'b0;
  bit          held_vld = 1'b0;
  logic [32:0] held = '0;
  int          bnd[14] = '{-2049, -2048, -1, 0, 1, 2047, 2048, -4097, -4096, 4094, 4095, 4096, 3, -3};
  word_t       t5w[3];
  int          idx;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Standard immediate extender, the inverse the encoder must satisfy.
  function automatic logic [31:0] ext(input logic [31:0] w, input logic [1:0] s);
    case (s)
      IMMSRC_I: return {{20{w[31]}}, w[31:20]};
      IMMSRC_S: return {{20{w[31]}}, w[31:25], w[11:7]};
      IMMSRC_B: return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      default:  return 32'h0;
    endcase
  endfunction

  // What survives truncation, by modular arithmetic on the signed value.
  function automatic logic [31:0] wrap_imm(input logic [1:0] s, input logic [31:0] imm);
    int v;
    v = imm;
    if (s == IMMSRC_B) return ((((v & -2) + 4096) & 8191) - 4096);
    return (((v + 2048) & 4095) - 2048);
  endfunction

  function automatic bit in_range(input logic [1:0] s, input logic [31:0] imm);
    int v;
    v = imm;
    case (s)
      IMMSRC_I, IMMSRC_S: return (v >= -2048) && (v <= 2047);
      IMMSRC_B:           return (v >= -4096) && (v <= 4095) && ((v & 1) == 0);
      default:            return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] field_mask(input logic [1:0] s);
    case (s)
      IMMSRC_I:           return 32'hFFF0_0000;
      IMMSRC_S, IMMSRC_B: return 32'hFE00_0F80;
      default:            return 32'h0;
    endcase
  endfunction

  function automatic bit exp_err(input word_t w);
    return ERR_ON && !in_range(w.src, w.imm);
  endfunction

  function automatic logic [31:0] rand_imm();
    int v;
    case ($urandom % 4)
      0:       v = int'($urandom_range(0, 8191)) - 4096;
      1:       v = bnd[$urandom % 14];
      2:       v = int'($urandom);
      default: v = int'($urandom_range(0, 63)) - 32;
    endcase
    return v;
  endfunction

  task automatic set_in(input bit v, input logic [1:0] s, input logic [31:0] imm, input logic [31:0] tmpl);
    bus.in_valid  = v;
    bus.in_immsrc = s;
    bus.in_imm    = imm;
    bus.in_instr  = tmpl;
  endtask

  // Called just after a falling edge with inputs already driven; returns after the next falling edge.
  task automatic cyc();
    word_t       w;
    bit          e;
    logic [31:0] m;
    #1;
    if (held_vld && bus.out_valid) check("hold_stable", {bus.out_err, bus.out_instr}, held);
    if (bus.out_valid && bus.out_ready) begin
      n_out++;
      check("sb_nonempty", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        w = sb.pop_front();
        e = exp_err(w);
        m = field_mask(w.src);
        check("out_err", bus.out_err, e);
        check("pass_fields", bus.out_instr & ~m, w.tmpl & ~m);
        if (w.src == IMMSRC_RSVD) check("rsvd_passthru", bus.out_instr, w.tmpl);
        else check("decode", ext(bus.out_instr, w.src), wrap_imm(w.src, w.imm));
        if (m_enc < CMAX) m_enc++;
        if (e && m_err < CMAX) m_err++;
      end
    end
    held_vld = bus.out_valid && !bus.out_ready;
    held     = {bus.out_err, bus.out_instr};
    last_acc = bus.in_valid && bus.in_ready;
    if (last_acc) sb.push_back('{bus.in_instr, bus.in_immsrc, bus.in_imm});
    @(negedge clk);
    check("enc_count", enc_count, m_enc);
    check("err_count", err_count, m_err);
  endtask

  task automatic do_reset();
    set_in(1'b0, 2'b00, 32'h0, 32'h0);
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    sb.delete();
    m_enc = 0;
    m_err = 0;
    held_vld = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    set_in(1'b0, 2'b00, 32'h0, 32'h0);
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_instr", bus.out_instr, 0);
    check("rst_out_err", bus.out_err, 0);
    check("rst_enc_count", enc_count, 0);
    check("rst_err_count", err_count, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed encodes, one cycle latency each.
    bus.out_ready = 1'b1;
    set_in(1'b1, IMMSRC_I, 32'hFFFF_F800, 32'h0000_0013);
    cyc();
    check("t1_valid", bus.out_valid, 1);
    check("t1_instr", bus.out_instr, 32'h8000_0013);
    check("t1_err", bus.out_err, 0);
    set_in(1'b1, IMMSRC_S, 32'h0000_007F, 32'h0000_2023);
    cyc();
    check("t2_instr", bus.out_instr, 32'h0600_2FA3);
    check("t2_err", bus.out_err, 0);
    set_in(1'b1, IMMSRC_B, 32'hFFFF_FFFC, 32'h0000_0063);
    cyc();
    check("t3_instr", bus.out_instr, 32'hFE00_0EE3);
    check("t3_err", bus.out_err, 0);
    check("t3_roundtrip", ext(bus.out_instr, IMMSRC_B), 32'hFFFF_FFFC);
    set_in(1'b0, 2'b00, 32'h0, 32'h0);
    cyc();

    // Out-of-range words.
    do_reset();
    bus.out_ready = 1'b1;
    set_in(1'b1, IMMSRC_B, 32'h0000_0003, 32'h0000_0063);
    cyc();
    check("t4_b_err", bus.out_err, ERR_ON);
    set_in(1'b1, IMMSRC_I, 32'h0000_0800, 32'h0000_0013);
    cyc();
    check("t4_i_err", bus.out_err, ERR_ON);
    set_in(1'b0, 2'b00, 32'h0, 32'h0);
    repeat (2) cyc();
    check("t4_enc_count", enc_count, 2);
    check("t4_err_count", err_count, ERR_ON ? 2 : 0);

    // Backpressure: two words absorbed, third waits.
    do_reset();
    t5w[0] = '{32'h0000_0013, IMMSRC_I, 32'h0000_0011};
    t5w[1] = '{32'h0000_2023, IMMSRC_S, 32'hFFFF_FF22};
    t5w[2] = '{32'h0000_0063, IMMSRC_B, 32'h0000_0444};
    idx = 0;
    n_out = 0;
    repeat (3) begin
      set_in(1'b1, t5w[idx].src, t5w[idx].imm, t5w[idx].tmpl);
      cyc();
      if (last_acc) idx++;
    end
    check("t5_accepted", idx, 2);
    check("t5_in_ready", bus.in_ready, 0);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 20 && !(idx == 3 && sb.size() == 0 && !bus.out_valid); k++) begin
      if (idx < 3) set_in(1'b1, t5w[idx].src, t5w[idx].imm, t5w[idx].tmpl);
      else set_in(1'b0, 2'b00, 32'h0, 32'h0);
      cyc();
      if (last_acc) idx++;
    end
    check("t5_all_accepted", idx, 3);
    check("t5_outputs", n_out, 3);

    // Random traffic; long enough to saturate the narrow counters.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      set_in(($urandom % 4) != 0, 2'($urandom % 4), rand_imm(), $urandom);
      bus.out_ready = ($urandom % 3) != 0;
      cyc();
    end
    set_in(1'b0, 2'b00, 32'h0, 32'h0);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 10 && (sb.size() != 0 || bus.out_valid); k++) cyc();
    check("drain_empty", sb.size(), 0);
    check("sat_enc_count", enc_count, CMAX);

    // Asynchronous reset while a word is held.
    bus.out_ready = 1'b0;
    set_in(1'b1, IMMSRC_I, 32'h0000_0005, 32'h0000_0013);
    cyc();
    set_in(1'b0, 2'b00, 32'h0, 32'h0);
    check("t6_pre_valid", bus.out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_out_valid", bus.out_valid, 0);
    check("t6_out_instr", bus.out_instr, 0);
    check("t6_enc_count", enc_count, 0);
    check("t6_err_count", err_count, 0);
    sb.delete();
    m_enc = 0;
    m_err = 0;
    held_vld = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_in_ready", bus.in_ready, 1);
    check("t6_still_empty", bus.out_valid, 0);
    bus.out_ready = 1'b1;
    set_in(1'b1, IMMSRC_S, 32'h0000_007F, 32'h0000_2023);
    cyc();
    check("t6_after_instr", bus.out_instr, 32'h0600_2FA3);
    set_in(1'b0, 2'b00, 32'h0, 32'h0);
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
